calc_sequencer: RTL

//  Sequential controller for the 5x5-bit switch calculator (add/sub/mul) with decimal 7-seg readout.
//  - Conditions the pushbuttons and latches the operands and operation on a clean press.
//  - Computes one result per press, then converts it to BCD with a multi-cycle shift-add-3 engine.
//  - Drives LEDR and HEX0..HEX3 from registers, so the outputs stay stable between operations.
//  - Sits directly between the board I/O and the display; it is the board top-level's only logic.

---
 rtl/calc_pkg.sv | 55 +++++
 rtl/calc_sequencer_if.sv | 26 ++
 rtl/key_debounce.sv | 54 +++++
 rtl/calc_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the switch calculator: operations, sequencer states,
// widths and the active-low 7-segment patterns.
package calc_pkg;

    localparam int OPW  = 5;
    localparam int RESW = 10;
    localparam int BCDW = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_CLR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CONV = 2'd2,
        ST_LOAD = 2'd3
    } state_e;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Board-side bundle of the calculator: switches and keys in, LEDs and
// seven-segment digits out, plus the sequencer state for observation.
interface calc_sequencer_if;
    import calc_pkg::*;

    logic [9:0] SW;
    logic [3:0] KEY;
    logic [9:0] LEDR;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    state_e     state;

    // The board (or bench) drives switches and keys and watches the displays.
    modport master (
        output SW, KEY,
        input  LEDR, HEX0, HEX1, HEX2, HEX3, state
    );

    modport slave (
        input  SW, KEY,
        output LEDR, HEX0, HEX1, HEX2, HEX3, state
    );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton: synchronizer, stability filter and a single-cycle pulse
// on the press (falling) edge of the filtered level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The filtered level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= key_n;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press = level_prev_q & ~level_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: latches operands on a clean key press, computes one
// result, converts it to BCD over RESW cycles and registers the display.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    calc_sequencer_if.slave  io
);

    logic [3:0] press;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key (
            .clk   (CLOCK_50),
            .rst   (RESET),
            .key_n (io.KEY[k]),
            .press (press[k])
        );
    end

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [OPW-1:0]    a_q, a_d;
    logic [OPW-1:0]    b_q, b_d;
    logic [RESW-1:0]   result_q, result_d;
    logic              sign_q, sign_d;
    logic [RESW-1:0]   bin_q, bin_d;
    logic [BCDW-1:0]   bcd_q, bcd_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [RESW-1:0]   ledr_q, ledr_d;
    logic [6:0]        hex0_q, hex0_d;
    logic [6:0]        hex1_q, hex1_d;
    logic [6:0]        hex2_q, hex2_d;
    logic [6:0]        hex3_q, hex3_d;

    logic [RESW-1:0]   exec_res;
    logic              exec_neg;
    logic [BCDW-1:0]   bcd_adj;

    // Subtraction yields a magnitude plus a sign flag, never two's complement
    always_comb begin
        exec_res = '0;
        exec_neg = 1'b0;
        case (op_q)
            OP_ADD: exec_res = RESW'(a_q) + RESW'(b_q);
            OP_SUB: begin
                if (a_q < b_q) begin
                    exec_res = RESW'(b_q - a_q);
                    exec_neg = 1'b1;
                end else begin
                    exec_res = RESW'(a_q - b_q);
                end
            end
            OP_MUL: exec_res = RESW'(a_q) * RESW'(b_q);
            default: exec_res = '0;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        sign_d   = sign_q;
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ledr_d   = ledr_q;
        hex0_d   = hex0_q;
        hex1_d   = hex1_q;
        hex2_d   = hex2_q;
        hex3_d   = hex3_q;
        case (state_q)
            ST_IDLE: begin
                if (press[3]) begin
                    op_d     = OP_ADD;
                    a_d      = '0;
                    b_d      = '0;
                    result_d = '0;
                    sign_d   = 1'b0;
                    ledr_d   = '0;
                    hex0_d   = SEG_0;
                    hex1_d   = SEG_0;
                    hex2_d   = SEG_0;
                    hex3_d   = SEG_0;
                end else if (|press[2:0]) begin
                    a_d     = io.SW[2*OPW-1:OPW];
                    b_d     = io.SW[OPW-1:0];
                    op_d    = press[0] ? OP_ADD : (press[1] ? OP_SUB : OP_MUL);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = exec_res;
                sign_d   = exec_neg;
                bin_d    = exec_res;
                bcd_d    = '0;
                cnt_d    = '0;
                state_d  = ST_CONV;
            end
            ST_CONV: begin
                bcd_d = {bcd_adj[BCDW-2:0], bin_q[RESW-1]};
                bin_d = {bin_q[RESW-2:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(RESW - 1)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ledr_d  = result_q;
                hex0_d  = seg7(bcd_q[3:0]);
                hex1_d  = seg7(bcd_q[7:4]);
                hex2_d  = seg7(bcd_q[11:8]);
                hex3_d  = sign_q ? SEG_MINUS : seg7(bcd_q[15:12]);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            sign_q   <= 1'b0;
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ledr_q   <= '0;
            hex0_q   <= SEG_0;
            hex1_q   <= SEG_0;
            hex2_q   <= SEG_0;
            hex3_q   <= SEG_0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            sign_q   <= sign_d;
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            ledr_q   <= ledr_d;
            hex0_q   <= hex0_d;
            hex1_q   <= hex1_d;
            hex2_q   <= hex2_d;
            hex3_q   <= hex3_d;
        end
    end

    assign io.LEDR  = ledr_q;
    assign io.HEX0  = hex0_q;
    assign io.HEX1  = hex1_q;
    assign io.HEX2  = hex2_q;
    assign io.HEX3  = hex3_q;
    assign io.state = state_q;

endmodule
